// File: rtl/cd_pkg.sv
// Shared definitions for the CD bus receive/transmit paths: FSM states,
// Modbus CRC16 constants and the byte-wide CRC update function.
package cd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CHECK,
        ST_WAIT_IDLE
    } cd_state_e;

    localparam logic [15:0] CD_CRC_INIT  = 16'hFFFF;
    localparam logic [15:0] CD_CRC_POLY  = 16'hA001;
    localparam logic [7:0]  CD_BROADCAST = 8'hFF;
    localparam int          CD_MAX_LEN   = 253;

    // Reflected CRC16, LSB first, one whole byte per call.
    function automatic logic [15:0] cd_crc_next(input logic [15:0] crc,
                                                input logic [7:0]  data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CD_CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/cd_crc16.sv
// Registered Modbus CRC16 accumulator; init restarts from CD_CRC_INIT and,
// together with en, folds the current byte into the fresh seed.
module cd_crc16
    import cd_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_base;

    assign crc_base = init ? CD_CRC_INIT : crc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc <= CD_CRC_INIT;
        end else if (en) begin
            crc <= cd_crc_next(crc_base, data);
        end else if (init) begin
            crc <= CD_CRC_INIT;
        end
    end

endmodule

// File: rtl/cd_rx_frame.sv
// Receive framer: parses src/dst/len, filters on dst, checks the CRC16 residue
// and streams accepted bytes to the frame buffer, committing with a switch pulse.
module cd_rx_frame
    import cd_pkg::*;
#(
    parameter int MAX_LEN = CD_MAX_LEN
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_byte_en,
    input  logic       frame_end,
    input  logic       abort,
    input  logic [7:0] filter,
    input  logic       promiscuous,
    input  logic       not_drop,
    output logic [7:0] wr_byte,
    output logic [7:0] wr_addr,
    output logic       wr_en,
    output logic       wr_err,
    output logic [7:0] wr_len,
    output logic       switch,
    output logic       rx_error,
    output logic       rx_break
);

    localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

    cd_state_e   state;
    cd_state_e   state_byte;
    logic [7:0]  cnt;
    logic [7:0]  addr_now;
    logic [8:0]  remain;
    logic [7:0]  len_q;
    logic        end_seen;
    logic        wr_now;
    logic        len_bad;
    logic        len_ok;
    logic        dst_match;
    logic        crc_init;
    logic        crc_en;
    logic [15:0] crc;

    assign crc_init  = (state == ST_IDLE);
    assign crc_en    = rx_byte_en && !abort &&
                       (state == ST_IDLE || state == ST_HDR || state == ST_DATA);
    assign addr_now  = (state == ST_IDLE) ? 8'd0 : cnt;
    assign dst_match = (rx_byte == filter) || (rx_byte == CD_BROADCAST) || promiscuous;

    cd_crc16 u_crc (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (crc_init),
        .en      (crc_en),
        .data    (rx_byte),
        .crc     (crc)
    );

    // Where the incoming byte alone would take the FSM; frame_end is applied afterwards.
    always_comb begin
        state_byte = state;
        wr_now     = 1'b0;
        len_bad    = 1'b0;
        len_ok     = 1'b0;
        if (rx_byte_en) begin
            case (state)
                ST_IDLE: begin
                    state_byte = ST_HDR;
                    wr_now     = 1'b1;
                end
                ST_HDR: begin
                    if (cnt == 8'd1) begin
                        wr_now = 1'b1;
                        if (!dst_match) state_byte = ST_WAIT_IDLE;
                    end else if ({1'b0, rx_byte} > MAX_LEN_W) begin
                        len_bad    = 1'b1;
                        state_byte = ST_WAIT_IDLE;
                    end else begin
                        len_ok     = 1'b1;
                        wr_now     = 1'b1;
                        state_byte = ST_DATA;
                    end
                end
                ST_DATA: begin
                    wr_now = 1'b1;
                    if (remain == 9'd1) state_byte = ST_CHECK;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= 8'd0;
            remain   <= 9'd0;
            len_q    <= 8'd0;
            end_seen <= 1'b0;
            wr_byte  <= 8'd0;
            wr_addr  <= 8'd0;
            wr_en    <= 1'b0;
            wr_err   <= 1'b0;
            wr_len   <= 8'd0;
            switch   <= 1'b0;
            rx_error <= 1'b0;
            rx_break <= 1'b0;
        end else begin
            wr_en    <= 1'b0;
            switch   <= 1'b0;
            rx_error <= 1'b0;
            rx_break <= 1'b0;
            if (abort) begin
                state    <= ST_IDLE;
                cnt      <= 8'd0;
                end_seen <= 1'b0;
            end else if (state == ST_CHECK) begin
                if (crc == 16'h0000) begin
                    switch <= 1'b1;
                    wr_err <= 1'b0;
                    wr_len <= len_q;
                end else begin
                    rx_error <= 1'b1;
                    if (not_drop) begin
                        switch <= 1'b1;
                        wr_err <= 1'b1;
                        wr_len <= len_q;
                    end
                end
                // An end already seen alongside crc_h means the bus is idle now.
                state    <= (end_seen || frame_end) ? ST_IDLE : ST_WAIT_IDLE;
                end_seen <= 1'b0;
            end else begin
                if (wr_now) begin
                    wr_en   <= 1'b1;
                    wr_byte <= rx_byte;
                    wr_addr <= addr_now;
                end
                if (rx_byte_en) cnt <= addr_now + 8'd1;
                if (len_ok) begin
                    len_q  <= rx_byte;
                    remain <= {1'b0, rx_byte} + 9'd2;
                end
                if (rx_byte_en && state == ST_DATA) remain <= remain - 9'd1;
                if (len_bad) rx_error <= 1'b1;

                case (state_byte)
                    ST_HDR, ST_DATA: begin
                        if (frame_end) begin
                            state    <= ST_IDLE;
                            rx_break <= 1'b1;
                        end else begin
                            state <= state_byte;
                        end
                    end
                    ST_CHECK: begin
                        state    <= ST_CHECK;
                        end_seen <= frame_end;
                    end
                    ST_WAIT_IDLE: state <= frame_end ? ST_IDLE : ST_WAIT_IDLE;
                    default:      state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/cd_rx_frame.md
# cd_rx_frame

Receive framer sitting directly upstream of the receive frame buffer. It consumes deserialized bytes from the bus receiver and parses the frame header (src, dst, len), address-filters it and checks the Modbus CRC16. It streams accepted bytes into the buffer's write port and commits each complete frame with a one-cycle `switch` pulse, with length and error flag attached.

## Interface
- `MAX_LEN`, 253: largest legal user-data length; larger `len` byte → frame dropped.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `rx_byte`  in  8  received byte.
- `rx_byte_en`  in  1  one-cycle strobe, `rx_byte` valid; at most one per 2 cycles.
- `frame_end`  in  1  one-cycle pulse, bus idle detected (frame boundary).
- `abort`  in  1  synchronous flush (tied to the buffer's flush-all); forces IDLE.
- `filter`  in  8  own address.
- `promiscuous`  in  1  accept any dst.
- `not_drop`  in  1  commit CRC-failed frames with `wr_err`=1 instead of dropping.
- `wr_byte`  out  8  byte to buffer.
- `wr_addr`  out  8  byte offset in frame (0 = src).
- `wr_en`  out  1  write strobe.
- `wr_err`  out  1  CRC-failed flag, valid with `switch`.
- `wr_len`  out  8  user-data length, valid with `switch`, held until next header.
- `switch`  out  1  commit pulse.
- `rx_error`  out  1  pulse: CRC failure or `len` > `MAX_LEN`.
- `rx_break`  out  1  pulse: `frame_end` before frame complete.

## Operation
- States: IDLE, HDR, DATA, CHECK, WAIT_IDLE.
- IDLE: first `rx_byte_en` → byte 0 (src), cnt=1, CRC seeded 16'hFFFF then updated, state HDR.
- HDR: byte 1 = dst, byte 2 = len.
  - Match rule: dst==`filter` || dst==8'hFF || `promiscuous`.
  - dst mismatch → WAIT_IDLE, no writes for rest of frame. Bytes 0..1 already written are harmless; no `switch`.
  - len > `MAX_LEN` → `rx_error`, WAIT_IDLE.
  - Otherwise latch len, go to DATA.
- DATA: every byte written at `wr_addr`=cnt, CRC updated; cnt is an 8-bit counter. Last byte is index len+4 (crc_h).
- CHECK (1 cycle after last byte's CRC update): residue == 16'h0000 → good.
  - Good → `switch`=1, `wr_err`=0, `wr_len`=len.
  - Bad & `not_drop` → `switch`=1, `wr_err`=1, plus `rx_error`.
  - Bad & !`not_drop` → `rx_error` only.
  - Then WAIT_IDLE.
- WAIT_IDLE: ignore bytes until `frame_end` → IDLE.
- `frame_end` in HDR/DATA → `rx_break`, IDLE, no `switch`.
- `frame_end` in IDLE: no effect.
- `frame_end` same cycle as `rx_byte_en`: byte processed first, then the end is evaluated against the updated count. If that byte was crc_h, the frame completes normally (CHECK still runs).
- `abort` has priority over everything: IDLE next cycle, pending `wr_en`/`switch` suppressed.
- CRC: Modbus CRC16, reflected poly 16'hA001, init 16'hFFFF, one byte per cycle, computed over bytes 0..len+4 including the CRC bytes.

## Timing
- Reset values: all outputs 0, state IDLE, cnt 0, CRC 16'hFFFF.
- `wr_en`/`wr_byte`/`wr_addr` registered: `rx_byte_en` at cycle N → `wr_en` at N+1.
- `switch` at N+2 after crc_h strobe at N. `wr_err` and `wr_len` are valid that cycle and remain stable ≥1 further cycle, because the buffer samples them one cycle late.
- Pulses (`wr_en`, `switch`, `rx_error`, `rx_break`) are exactly one cycle wide.
- Back-to-back frames: a new frame is accepted the cycle after `frame_end` is processed.

## Structure
- Shared package `cd_pkg`: state enum, `CD_CRC_INIT`=16'hFFFF, `CD_CRC_POLY`=16'hA001, `CD_BROADCAST`=8'hFF, default `MAX_LEN`.
- Sub-module `cd_crc16`: byte-wide combinational next-CRC function plus register, with `init` and `en` inputs; reused by the transmit path.

## Test plan
- Frame 01 05 02 AA BB + valid CRC, `filter`=05 → 7 writes at addr 0..6, then `switch`, `wr_len`=2, `wr_err`=0.
- Same frame with CRC byte flipped, `not_drop`=0 → 7 writes, `rx_error`, no `switch`; with `not_drop`=1 → `switch` with `wr_err`=1.
- dst=07, `filter`=05 → no `switch`. Repeat with dst=FF → accepted; repeat with `promiscuous`=1 → accepted.
- `frame_end` after byte 4 of a len=2 frame → `rx_break`, no `switch`; next valid frame is accepted normally.
- len=254 → `rx_error`, WAIT_IDLE. len=253 → 258 writes, last at addr 257 mod 256 = 1, `switch`.
- `abort` mid-DATA, and `reset_n` low mid-frame → outputs 0, IDLE; following frame commits correctly.
